// File: rtl/rpn_pkg.sv
// Shared constants for the RPN evaluator.
// Holds the token kinds, ALU op codes, the FSM state encoding and the bit
// positions inside the error vector.
package rpn_pkg;

    // Token kind field, top two bits of a program token
    localparam logic [1:0] KIND_CONST = 2'd0;
    localparam logic [1:0] KIND_VAR   = 2'd1;
    localparam logic [1:0] KIND_OP    = 2'd2;
    localparam logic [1:0] KIND_NOP   = 2'd3;

    // Operation code, low two payload bits of an OP token
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_NEG = 2'd3;

    // Bit positions inside error = {bad_length, overflow, underflow}
    localparam int ERR_UNDERFLOW  = 0;
    localparam int ERR_OVERFLOW   = 1;
    localparam int ERR_BAD_LENGTH = 2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFetch  = 2'd1,
        StExec   = 2'd2,
        StFinish = 2'd3
    } state_t;

endpackage

// File: rtl/rpn_alu.sv
// Combinational signed fixed-point ALU for the RPN evaluator.
// Ports:
//   a, b : operands (a is the deeper stack entry, b the top)
//   op   : OP_ADD / OP_SUB / OP_MUL / OP_NEG (NEG uses a only)
//   y    : result, NUMBER_WIDTH bits, two's complement wrap
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH    = 8,
    parameter int FRACTIONAL_PART_WIDTH = 8,
    localparam int NUMBER_WIDTH = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
) (
    input  logic [NUMBER_WIDTH-1:0] a,
    input  logic [NUMBER_WIDTH-1:0] b,
    input  logic [1:0]              op,
    output logic [NUMBER_WIDTH-1:0] y
);

    logic signed [2*NUMBER_WIDTH-1:0] prod;

    always_comb begin
        // Sign-extend both operands so the low 2*NW bits are the exact signed product
        prod = {{NUMBER_WIDTH{a[NUMBER_WIDTH-1]}}, a} * {{NUMBER_WIDTH{b[NUMBER_WIDTH-1]}}, b};
        y    = '0;
        unique case (op)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            // Arithmetic shift floors the product, i.e. rounds toward minus infinity
            OP_MUL: y = NUMBER_WIDTH'(prod >>> FRACTIONAL_PART_WIDTH);
            OP_NEG: y = '0 - a;
        endcase
    end

endmodule

// File: rtl/rpn_evaluator.sv
// Reverse-Polish fixed-point expression evaluator.
// A program of tokens is loaded through the write port, then start runs it
// once: every token takes a fetch cycle and an execute cycle on a private
// operand stack. The top of stack and an error vector are reported with done.
// Ports:
//   clk, rst_n                          : clock, synchronous active-low reset
//   prog_wr_en/prog_wr_addr/prog_wr_data: program memory write port (ignored while busy)
//   prog_len, x, start                  : token count and variable value, sampled at start
//   busy, done, result, error           : status and result; error = {bad_length, overflow, underflow}
module rpn_evaluator
    import rpn_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH    = 8,
    parameter int FRACTIONAL_PART_WIDTH = 8,
    parameter int STACK_SIZE            = 16,
    parameter int PROGRAM_SIZE          = 64,
    localparam int NUMBER_WIDTH = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
    localparam int TOKEN_WIDTH  = 2 + NUMBER_WIDTH,
    localparam int AW           = $clog2(PROGRAM_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    prog_wr_en,
    input  logic [AW-1:0]           prog_wr_addr,
    input  logic [TOKEN_WIDTH-1:0]  prog_wr_data,
    input  logic [AW:0]             prog_len,
    input  logic                    start,
    input  logic [NUMBER_WIDTH-1:0] x,
    output logic                    busy,
    output logic                    done,
    output logic [NUMBER_WIDTH-1:0] result,
    output logic [2:0]              error
);

    localparam int SPW = $clog2(STACK_SIZE + 1);
    localparam int IW  = $clog2(STACK_SIZE);
    localparam logic [SPW-1:0] STACK_FULL = SPW'(STACK_SIZE);
    localparam logic [AW:0]    PROG_MAX   = (AW + 1)'(PROGRAM_SIZE);

    logic [TOKEN_WIDTH-1:0]  prog_mem [PROGRAM_SIZE];
    logic [NUMBER_WIDTH-1:0] stack    [STACK_SIZE];

    state_t                  state;
    logic [AW-1:0]           pc;
    logic [SPW-1:0]          stack_p;
    logic [AW:0]             len_lat;
    logic [NUMBER_WIDTH-1:0] x_lat;
    logic [TOKEN_WIDTH-1:0]  token;

    // Decoded effect of the token currently in EXEC
    logic [1:0]              kind;
    logic [NUMBER_WIDTH-1:0] payload;
    logic [1:0]              op;
    logic [IW-1:0]           top_idx, sec_idx, wr_idx;
    logic [NUMBER_WIDTH-1:0] cur_top, alu_a, alu_y, wr_val, top_after;
    logic [SPW-1:0]          sp_after;
    logic                    stack_we, ovf, udf, more;
    logic [2:0]              err_exec, err_end;

    rpn_alu #(
        .INTEGER_PART_WIDTH   (INTEGER_PART_WIDTH),
        .FRACTIONAL_PART_WIDTH(FRACTIONAL_PART_WIDTH)
    ) u_alu (
        .a (alu_a),
        .b (cur_top),
        .op(op),
        .y (alu_y)
    );

    always_comb begin
        kind     = token[TOKEN_WIDTH-1:NUMBER_WIDTH];
        payload  = token[NUMBER_WIDTH-1:0];
        op       = payload[1:0];
        // Guarded indices keep reads in range when the stack is (nearly) empty
        top_idx  = (stack_p == '0) ? '0 : IW'(stack_p - SPW'(1));
        sec_idx  = (stack_p < SPW'(2)) ? '0 : IW'(stack_p - SPW'(2));
        cur_top  = (stack_p == '0) ? '0 : stack[top_idx];
        alu_a    = (op == OP_NEG) ? stack[top_idx] : stack[sec_idx];
        stack_we = 1'b0;
        wr_idx   = IW'(stack_p);
        wr_val   = '0;
        sp_after = stack_p;
        ovf      = 1'b0;
        udf      = 1'b0;
        case (kind)
            KIND_CONST, KIND_VAR: begin
                stack_we = 1'b1;
                wr_val   = (kind == KIND_CONST) ? payload : x_lat;
                sp_after = stack_p + SPW'(1);
                ovf      = (stack_p == STACK_FULL);
            end
            KIND_OP: begin
                stack_we = 1'b1;
                wr_val   = alu_y;
                if (op == OP_NEG) begin
                    wr_idx = top_idx;
                    udf    = (stack_p == '0);
                end else begin
                    wr_idx   = sec_idx;
                    sp_after = stack_p - SPW'(1);
                    udf      = (stack_p < SPW'(2));
                end
            end
            default: ;
        endcase
        // Every write lands on the new top, so the post-token top is known this cycle
        top_after = (sp_after == '0) ? '0 : (stack_we ? wr_val : cur_top);
        more      = (({1'b0, pc} + (AW + 1)'(1)) < len_lat);
        err_exec  = '0;
        err_exec[ERR_OVERFLOW]  = ovf;
        err_exec[ERR_UNDERFLOW] = udf;
        err_end   = '0;
        err_end[ERR_BAD_LENGTH] = (sp_after != SPW'(1));
    end

    always_ff @(posedge clk) begin
        if (prog_wr_en && !busy) begin
            prog_mem[prog_wr_addr] <= prog_wr_data;
        end
    end

    // A faulting token leaves the stack untouched
    always_ff @(posedge clk) begin
        if (rst_n && state == StExec && stack_we && !ovf && !udf) begin
            stack[wr_idx] <= wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            error   <= '0;
            pc      <= '0;
            stack_p <= '0;
            len_lat <= '0;
            x_lat   <= '0;
            token   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        x_lat   <= x;
                        len_lat <= prog_len;
                        pc      <= '0;
                        stack_p <= '0;
                        busy    <= 1'b1;
                        if (prog_len == '0 || prog_len > PROG_MAX) begin
                            state  <= StFinish;
                            done   <= 1'b1;
                            result <= '0;
                            error  <= 3'(1 << ERR_BAD_LENGTH);
                        end else begin
                            state <= StFetch;
                        end
                    end
                end
                StFetch: begin
                    token <= prog_mem[pc];
                    state <= StExec;
                end
                StExec: begin
                    if (ovf || udf) begin
                        state  <= StFinish;
                        done   <= 1'b1;
                        result <= cur_top;
                        error  <= err_exec;
                    end else begin
                        stack_p <= sp_after;
                        pc      <= pc + AW'(1);
                        if (more) begin
                            state <= StFetch;
                        end else begin
                            state  <= StFinish;
                            done   <= 1'b1;
                            result <= top_after;
                            error  <= err_end;
                        end
                    end
                end
                StFinish: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_evaluator.sv
// Directed bench for rpn_evaluator (Q8.8 defaults) with hand-computed results.
module tb_rpn_evaluator;

    logic        clk;
    logic        rst_n;
    logic        prog_wr_en;
    logic [5:0]  prog_wr_addr;
    logic [17:0] prog_wr_data;
    logic [6:0]  prog_len;
    logic        start;
    logic [15:0] x;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [2:0]  error;

    int n_cmp;
    int n_bad;
    logic [17:0] prog [64];

    rpn_evaluator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prog_wr_en  (prog_wr_en),
        .prog_wr_addr(prog_wr_addr),
        .prog_wr_data(prog_wr_data),
        .prog_len    (prog_len),
        .start       (start),
        .x           (x),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .error       (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] tok(input logic [1:0] k, input logic [15:0] p);
        return {k, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            prog_wr_en   = 1'b1;
            prog_wr_addr = 6'(i);
            prog_wr_data = prog[i];
            tick();
        end
        prog_wr_en = 1'b0;
    endtask

    // Pulses start; returns in the first cycle after the accepting edge
    task automatic kick(input int len, input logic [15:0] xv);
        prog_len = 7'(len);
        x        = xv;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_check(input string tag, input int cyc0, input int exp_cyc,
                              input logic [15:0] exp_res, input logic [2:0] exp_err,
                              input bit chk_res);
        int cyc;
        cyc = cyc0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        check_eq({tag, " latency"}, cyc, exp_cyc);
        if (chk_res) check_eq({tag, " result"}, {16'h0, result}, {16'h0, exp_res});
        check_eq({tag, " error"}, {29'h0, error}, {29'h0, exp_err});
        tick();
        check_eq({tag, " done pulse"}, {31'h0, done}, 32'h0);
    endtask

    task automatic run(input string tag, input int len, input logic [15:0] xv, input int exp_cyc,
                       input logic [15:0] exp_res, input logic [2:0] exp_err, input bit chk_res);
        load(len);
        kick(len, xv);
        check_eq({tag, " busy"}, {31'h0, busy}, 32'h1);
        wait_check(tag, 1, exp_cyc, exp_res, exp_err, chk_res);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        prog_wr_en   = 1'b0;
        prog_wr_addr = '0;
        prog_wr_data = '0;
        prog_len     = '0;
        start        = 1'b0;
        x            = '0;
        repeat (3) tick();
        check_eq("reset busy", {31'h0, busy}, 32'h0);
        check_eq("reset done", {31'h0, done}, 32'h0);
        check_eq("reset result", {16'h0, result}, 32'h0);
        check_eq("reset error", {29'h0, error}, 32'h0);
        rst_n = 1'b1;
        tick();

        // x^2 + 1 with x = 2.0
        prog[0] = tok(2'd1, 16'h0); prog[1] = tok(2'd1, 16'h0); prog[2] = tok(2'd2, 16'h2);
        prog[3] = tok(2'd0, 16'h0100); prog[4] = tok(2'd2, 16'h0);
        run("poly", 5, 16'h0200, 11, 16'h0500, 3'b000, 1'b1);
        check_eq("idle busy", {31'h0, busy}, 32'h0);

        prog[0] = tok(2'd0, 16'h7F00); prog[1] = tok(2'd0, 16'h0200); prog[2] = tok(2'd2, 16'h0);
        run("add wrap", 3, 16'h0, 7, 16'h8100, 3'b000, 1'b1);

        prog[0] = tok(2'd0, 16'hFF00); prog[1] = tok(2'd0, 16'h0080); prog[2] = tok(2'd2, 16'h2);
        run("mul neg", 3, 16'h0, 7, 16'hFF80, 3'b000, 1'b1);

        // -1/256 * 0.5 floors to -1/256
        prog[0] = tok(2'd1, 16'h0); prog[1] = tok(2'd0, 16'h0080); prog[2] = tok(2'd2, 16'h2);
        run("mul floor", 3, 16'hFFFF, 7, 16'hFFFF, 3'b000, 1'b1);

        prog[0] = tok(2'd0, 16'h8000); prog[1] = tok(2'd2, 16'h3);
        run("neg min", 2, 16'h0, 5, 16'h8000, 3'b000, 1'b1);

        prog[0] = tok(2'd0, 16'h0100); prog[1] = tok(2'd0, 16'h0300); prog[2] = tok(2'd2, 16'h1);
        run("sub", 3, 16'h0, 7, 16'hFE00, 3'b000, 1'b1);

        prog[0] = tok(2'd0, 16'h0400); prog[1] = tok(2'd3, 16'h0);
        run("nop", 2, 16'h0, 5, 16'h0400, 3'b000, 1'b1);

        prog[0] = tok(2'd2, 16'h0);
        run("underflow", 1, 16'h0, 3, 16'h0, 3'b001, 1'b0);

        // Underflow on the first of three tokens ends the run early
        prog[0] = tok(2'd2, 16'h0); prog[1] = tok(2'd0, 16'h0100); prog[2] = tok(2'd0, 16'h0200);
        run("early stop", 3, 16'h0, 3, 16'h0, 3'b001, 1'b0);

        for (int i = 0; i < 17; i++) prog[i] = tok(2'd0, 16'(i + 1));
        run("overflow", 17, 16'h0, 35, 16'h0, 3'b010, 1'b0);

        prog[0] = tok(2'd0, 16'h0100);
        run("len zero", 0, 16'h0, 1, 16'h0, 3'b100, 1'b1);

        prog[0] = tok(2'd0, 16'h0100); prog[1] = tok(2'd0, 16'h0300);
        run("two consts", 2, 16'h0, 5, 16'h0300, 3'b100, 1'b1);

        // Write and restart attempts while busy must be ignored
        prog[0] = tok(2'd0, 16'h0100); prog[1] = tok(2'd0, 16'h0200); prog[2] = tok(2'd2, 16'h0);
        load(3);
        kick(3, 16'h0);
        prog_wr_en   = 1'b1;
        prog_wr_addr = 6'd2;
        prog_wr_data = tok(2'd0, 16'h0900);
        start        = 1'b1;
        tick();
        prog_wr_en   = 1'b0;
        start        = 1'b0;
        wait_check("busy write", 2, 7, 16'h0300, 3'b000, 1'b1);
        check_eq("no restart", {31'h0, busy}, 32'h0);

        // Reset in EXEC of the first token, then a clean rerun
        prog[0] = tok(2'd1, 16'h0); prog[1] = tok(2'd1, 16'h0); prog[2] = tok(2'd2, 16'h2);
        prog[3] = tok(2'd0, 16'h0100); prog[4] = tok(2'd2, 16'h0);
        load(5);
        prog[0] = tok(2'd0, 16'h0100); prog[1] = tok(2'd0, 16'h0300);
        load(2);
        kick(2, 16'h0);
        wait_check("pre reset", 1, 5, 16'h0300, 3'b100, 1'b1);
        prog[0] = tok(2'd1, 16'h0); prog[1] = tok(2'd1, 16'h0);
        load(2);
        kick(5, 16'h0200);
        tick();
        rst_n = 1'b0;
        tick();
        check_eq("mid reset busy", {31'h0, busy}, 32'h0);
        check_eq("mid reset done", {31'h0, done}, 32'h0);
        check_eq("mid reset result", {16'h0, result}, 32'h0);
        check_eq("mid reset error", {29'h0, error}, 32'h0);
        rst_n = 1'b1;
        tick();
        kick(5, 16'h0200);
        wait_check("after reset", 1, 11, 16'h0500, 3'b000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
